// File: rtl/i3c2_reg_capture.sv
// Shadow register bank for I2C sequencer read results.
// Drains changed entries round-robin as {addr,data} records on a valid/ready stream.
module i3c2_reg_capture #(
    parameter int         CHANGE_ONLY = 1,
    parameter logic [7:0] RESET_DATA  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] reg_addr,
    input  logic [7:0] reg_data,
    input  logic       reg_write,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_addr,
    output logic [7:0] out_data,
    output logic [5:0] dirty_count,
    output logic       overrun,
    input  logic       clr_overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] bank [32];
    logic [31:0] written;
    logic [31:0] dirty;
    logic [4:0] scan_ptr;

    logic hit;
    logic latch;
    logic wr_diff;
    logic wr_mark;
    logic wr_ovr;
    logic keep;
    logic cnt_inc;
    logic cnt_dec;

    assign hit     = dirty[scan_ptr];
    assign latch   = (state == SCAN) && hit;
    assign wr_diff = (reg_data != bank[reg_addr]);
    assign wr_mark = reg_write &&
                     ((CHANGE_ONLY == 0) || !written[reg_addr] || wr_diff);
    assign wr_ovr  = reg_write && dirty[reg_addr] && wr_diff;
    // A marking write to the entry being latched keeps it dirty.
    assign keep    = wr_mark && (reg_addr == scan_ptr);
    assign cnt_inc = wr_mark && !dirty[reg_addr];
    assign cnt_dec = latch && !keep;

    // Bank, written/dirty flags, dirty counter, overrun and read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                bank[i] <= RESET_DATA;
            end
            written     <= '0;
            dirty       <= '0;
            dirty_count <= '0;
            overrun     <= 1'b0;
            rd_data     <= RESET_DATA;
        end else begin
            rd_data <= bank[rd_addr];
            if (reg_write) begin
                bank[reg_addr]    <= reg_data;
                written[reg_addr] <= 1'b1;
            end
            if (cnt_dec) begin
                dirty[scan_ptr] <= 1'b0;
            end
            if (wr_mark) begin
                dirty[reg_addr] <= 1'b1;
            end
            dirty_count <= dirty_count + {5'd0, cnt_inc} - {5'd0, cnt_dec};
            if (wr_ovr) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    // Drain FSM: round-robin scan, latch a dirty entry, hold until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            scan_ptr  <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (dirty_count != 6'd0) begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        out_addr  <= scan_ptr;
                        out_data  <= bank[scan_ptr];
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        scan_ptr <= scan_ptr + 5'd1;
                        if (dirty_count == 6'd0) begin
                            state <= IDLE;
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        scan_ptr  <= scan_ptr + 5'd1;
                        state     <= SCAN;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i3c2_reg_capture.sv
// Scoreboard bench for i3c2_reg_capture.
// Expected records queued at write time, compared on each handshake.
module tb_i3c2_reg_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] reg_addr;
    logic [7:0] reg_data;
    logic       reg_write;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_addr;
    logic [7:0] out_data;
    logic [5:0] dirty_count;
    logic       overrun;
    logic       clr_overrun;

    int n_chk = 0;
    int n_err = 0;
    logic [12:0] sb_q [$];

    i3c2_reg_capture #(.CHANGE_ONLY(1), .RESET_DATA(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .reg_write   (reg_write),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .dirty_count (dirty_count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Handshake monitor: inputs change just after posedge, so negedge
    // sees the values the next edge will act on.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rec", {19'd0, out_addr, out_data}, 32'h0);
            end else begin
                chk("rec", {19'd0, out_addr, out_data},
                    {19'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_data  = d;
        reg_write = 1'b1;
        step();
        reg_write = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100 && !out_valid; i++) step();
        chk("valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            done = (sb_q.size() == 0) && (dirty_count == 6'd0) && !out_valid;
        end
        chk("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        reg_addr = '0;
        reg_data = '0;
        reg_write = 1'b0;
        rd_addr = '0;
        out_ready = 1'b0;
        clr_overrun = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {26'd0, dirty_count}, 32'd0);
        chk("rst_rd", {24'd0, rd_data}, 32'h00);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // single write drains one record
        out_ready = 1'b1;
        sb_q.push_back({5'd3, 8'hA5});
        wr(5'd3, 8'hA5);
        chk("t2_count1", {26'd0, dirty_count}, 32'd1);
        wait_drain();
        chk("t2_count0", {26'd0, dirty_count}, 32'd0);

        // repeated identical writes produce one record
        sb_q.push_back({5'd7, 8'h3C});
        reg_addr = 5'd7;
        reg_data = 8'h3C;
        reg_write = 1'b1;
        repeat (20) step();
        reg_write = 1'b0;
        wait_drain();

        // read-before-write on the random-access port
        rd_addr = 5'd12;
        sb_q.push_back({5'd12, 8'h5A});
        wr(5'd12, 8'h5A);
        chk("rd_old", {24'd0, rd_data}, 32'h00);
        step();
        chk("rd_new", {24'd0, rd_data}, 32'h5A);
        wait_drain();

        // wrap order starting at scan_ptr 30
        out_ready = 1'b0;
        sb_q.push_back({5'd29, 8'h29});
        wr(5'd29, 8'h29);
        wait_valid();
        sb_q.push_back({5'd30, 8'h30});
        wr(5'd30, 8'h30);
        sb_q.push_back({5'd31, 8'h31});
        wr(5'd31, 8'h31);
        sb_q.push_back({5'd0, 8'h40});
        wr(5'd0, 8'h40);
        sb_q.push_back({5'd1, 8'h41});
        wr(5'd1, 8'h41);
        chk("t4_count", {26'd0, dirty_count}, 32'd4);
        chk("t4_hold", {19'd0, out_addr, out_data}, {19'd0, 5'd29, 8'h29});
        out_ready = 1'b1;
        wait_drain();

        // overwrite before drain sets overrun
        out_ready = 1'b0;
        sb_q.push_back({5'd20, 8'h01});
        wr(5'd20, 8'h01);
        wait_valid();
        wr(5'd5, 8'h11);
        chk("t5_ovr0", {31'd0, overrun}, 32'd0);
        sb_q.push_back({5'd5, 8'h22});
        wr(5'd5, 8'h22);
        chk("t5_ovr1", {31'd0, overrun}, 32'd1);
        chk("t5_count", {26'd0, dirty_count}, 32'd1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("t5_clr", {31'd0, overrun}, 32'd0);
        out_ready = 1'b1;
        wait_drain();

        // write to entry at the moment SCAN latches it
        out_ready = 1'b0;
        sb_q.push_back({5'd8, 8'h77});
        wr(5'd8, 8'h77);
        wait_valid();
        sb_q.push_back({5'd9, 8'h10});
        wr(5'd9, 8'h10);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        sb_q.push_back({5'd9, 8'h44});
        wr(5'd9, 8'h44);
        chk("t6_latch", {18'd0, out_valid, out_addr, out_data},
            {18'd0, 1'b1, 5'd9, 8'h10});
        chk("t6_count", {26'd0, dirty_count}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("t6_between", {26'd0, dirty_count}, 32'd1);
        wait_drain();

        // reset in the middle of a presented record
        out_ready = 1'b0;
        rd_addr = 5'd15;
        wr(5'd15, 8'hEE);
        wait_valid();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t1_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_count", {26'd0, dirty_count}, 32'd0);
        chk("t1_rd", {24'd0, rd_data}, 32'h00);
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("t1_quiet", {31'd0, out_valid}, 32'd0);
        chk("sb_left", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
